regfile_hazard_ctrl: RTL and testbench
======================================

# regfile_hazard_ctrl

Pipeline hazard controller for the 5-stage CPU's register file. It keeps a shadow pipeline of destination-register tags for EX, MEM and WB, and compares them against the source registers of the instruction in ID. From that it produces the load-use stall and the registered forwarding selects used by the EX-stage operand muxes. The register file writes on posedge and reads on negedge, so a WB-stage producer never needs forwarding or a stall.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall counter.

Ports:
- CLK  in  1  pipeline clock; all state updates on posedge CLK.
- RST_N  in  1  synchronous reset, active-low (sampled on posedge CLK).
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  ID source register numbers.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- id_rd  in  5  ID destination register.
- id_reg_write  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is a load; its data is ready only at the end of MEM.
- flush  in  1  squash the ID instruction (branch/jump redirect).
- stall  out  1  combinational; hold IF/ID and insert a bubble into EX.
- fwd_a, fwd_b  out  2  registered; operand select for the instruction now in EX: 00 = regfile RD1/RD2, 10 = EX/MEM ALU result, 01 = MEM/WB writeback data, 11 never driven.
- stall_count  out  CNT_W  number of stall cycles, saturating.

## Operation
- Shadow entries EX, MEM and WB each hold {v, rd[4:0], ld}.
  - v = instruction valid && reg_write && rd != 0.
  - Register x0 never creates a hazard.
- Per-source match:
  - mE = v_EX && rd_EX == rs.
  - mM = v_MEM && rd_MEM == rs.
  - Each match is qualified by id_use_rsN.
- stall = RST_N && id_valid && !flush && ld_EX && ((use_rs1 && mE(rs1)) || (use_rs2 && mE(rs2))).
- Next forward select per source, in priority order (the most recent producer wins):
  - mE && !ld_EX -> 10. The producer will be in MEM when the consumer reaches EX.
  - Otherwise mM -> 01. The producer will be in WB.
  - Otherwise -> 00.
  - A load in MEM (mM with ld_MEM) also gives 01; this is the post-stall load-use case.
- fwd_a and fwd_b load 00 when !id_valid, stall or flush.
- No state machine beyond the shift pipeline. Each posedge while RST_N = 1:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= {id_valid && id_reg_write && id_rd != 0 && !stall && !flush, id_rd, id_is_load}. A stall or flush inserts a bubble (v = 0).
  - fwd_a/fwd_b <= next selects.
  - stall_count <= stall_count + 1 when stall = 1 and stall_count != all-ones; otherwise hold.

## Timing
- Reset (RST_N = 0 at posedge):
  - All shadow v = 0, fwd_a = fwd_b = 00, stall_count = 0.
  - stall is forced to 0 while RST_N = 0.
  - Reset mid-stall drops the stall in the same cycle and discards all in-flight tags.
- stall is combinational, same cycle as ID inputs and EX state, and lasts exactly 1 cycle per load-use pair. The next cycle the load sits in MEM and the consumer gets fwd 01.
- fwd_a/fwd_b apply one cycle after the instruction is sampled in ID, i.e. while it is in EX.
- When both EX and MEM write the same rd, select 10 (EX priority).
- A producer in WB at the consumer's ID cycle needs no forwarding: the posedge write and negedge read resolve it. Select 00.
- flush together with a load-use match: flush wins. stall = 0, bubble inserted, counter not incremented.
- Both sources matching the same load: a single 1-cycle stall; after it, fwd_a = fwd_b = 01.
- The counter saturates at 2^CNT_W-1 and never wraps.

## Test plan
- Reset: hold RST_N = 0 for 2 cycles with id_valid = 1 and a load-use pattern present -> stall = 0 throughout; after release fwd_a = fwd_b = 00 and stall_count = 0.
- ALU distance 1: add x5 then sub rs1 = x5 -> stall stays 0; next cycle fwd_a = 10, fwd_b = 00.
- ALU distance 2: add x5, nop, or rs2 = x5 -> fwd_b = 01; at distance 3 -> fwd_b = 00.
- Load-use: lw x7 then add rs1 = x7, rs2 = x7 -> stall = 1 for exactly 1 cycle and stall_count = 1; the following cycle fwd_a = fwd_b = 01.
- x0 and priority: addi x0 then use of x0 -> fwd 00, no stall. add x3 followed by sub x3, then use of x3 -> fwd 10.
- Flush on load-use, plus saturation: flush = 1 in the load-use cycle -> stall = 0, stall_count unchanged, and the next instruction sees no EX match. Preload or run with CNT_W = 2 for 5 load-use stalls -> stall_count stops at 3.

Source files
------------

// File: rtl/regfile_hazard_ctrl.sv
// regfile_hazard_ctrl
// Hazard controller for the 5-stage pipeline's register file.
// It tracks destination-register tags for the instructions in EX and MEM and
// compares them with the sources of the instruction in ID. From that compare it
// produces three things:
//   - the combinational load-use stall,
//   - the registered EX operand forwarding selects,
//   - a saturating count of stall cycles.
// A producer in WB is resolved by the register file itself: it writes on the
// posedge and reads on the negedge. Because of that, only the EX and MEM tags
// are kept here.
// The load flag is needed only for the EX entry. A load in MEM forwards the
// same way as an ALU result in MEM.

module regfile_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    logic       ex_v;
    logic [4:0] ex_rd;
    logic       ex_ld;
    logic       mem_v;
    logic [4:0] mem_rd;

    logic       me1;
    logic       me2;
    logic       mm1;
    logic       mm2;
    logic       issue_v;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // Compare the ID sources with the EX/MEM tags, then derive the stall and the tag entering EX.
    always_comb begin
        me1     = id_use_rs1 && ex_v  && (ex_rd  == id_rs1);
        me2     = id_use_rs2 && ex_v  && (ex_rd  == id_rs2);
        mm1     = id_use_rs1 && mem_v && (mem_rd == id_rs1);
        mm2     = id_use_rs2 && mem_v && (mem_rd == id_rs2);
        stall   = RST_N && id_valid && !flush && ex_ld && (me1 || me2);
        issue_v = id_valid && id_reg_write && (id_rd != 5'd0) && !stall && !flush;
    end

    // Pick the next operand selects; the most recent producer wins, and a bubble gets regfile data.
    always_comb begin
        sel_a = SEL_RF;
        sel_b = SEL_RF;
        if (id_valid && !stall && !flush) begin
            if (me1 && !ex_ld) begin
                sel_a = SEL_MEM;
            end else if (mm1) begin
                sel_a = SEL_WB;
            end
            if (me2 && !ex_ld) begin
                sel_b = SEL_MEM;
            end else if (mm2) begin
                sel_b = SEL_WB;
            end
        end
    end

    // Advance the tag pipeline, register the selects and count stall cycles with saturation.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ex_v        <= 1'b0;
            ex_rd       <= 5'd0;
            ex_ld       <= 1'b0;
            mem_v       <= 1'b0;
            mem_rd      <= 5'd0;
            fwd_a       <= SEL_RF;
            fwd_b       <= SEL_RF;
            stall_count <= '0;
        end else begin
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            ex_v   <= issue_v;
            ex_rd  <= id_rd;
            ex_ld  <= id_is_load;
            fwd_a  <= sel_a;
            fwd_b  <= sel_b;
            if (stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_regfile_hazard_ctrl.sv
// Bench for regfile_hazard_ctrl.
// It runs two instances from the same stimulus: one with the default counter
// width and one with a 2-bit counter, so that saturation is exercised.
// The directed table covers the hand-derived scenarios. The random phase is
// checked against a history-based reference model.

module tb_regfile_hazard_ctrl;

    localparam int CW = 16;
    localparam int SW = 2;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       fl;
        logic       expStall;
        logic [1:0] expA;
        logic [1:0] expB;
        int         expCnt;
    } vec_t;

    typedef struct {
        logic       w;
        logic [4:0] rd;
        logic       ld;
    } issued_t;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          id_valid;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [4:0]    id_rd;
    logic          id_reg_write;
    logic          id_is_load;
    logic          flush;
    logic          stall;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [CW-1:0] stall_count;
    logic          stall_s;
    logic [1:0]    fwd_a_s;
    logic [1:0]    fwd_b_s;
    logic [SW-1:0] cnt_s;

    int total = 0;
    int bad   = 0;

    // hist[0] is the instruction issued most recently (now in EX); hist[1] is the one before it (in MEM).
    issued_t hist [2];
    logic [1:0] mA;
    logic [1:0] mB;
    int         c16;
    int         c2;
    vec_t       tbl [$];

    always #5 CLK = ~CLK;

    regfile_hazard_ctrl #(.CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count)
    );

    regfile_hazard_ctrl #(.CNT_W(SW)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .flush(flush), .stall(stall_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
        .stall_count(cnt_s)
    );

    function automatic vec_t mk(input logic rst_n, input logic valid,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic [4:0] rd, input logic rw,
                                input logic ld, input logic fl,
                                input logic eS, input logic [1:0] eA,
                                input logic [1:0] eB, input int eC);
        vec_t v;
        v.rst_n = rst_n; v.valid = valid; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.rd = rd; v.rw = rw; v.ld = ld; v.fl = fl;
        v.expStall = eS; v.expA = eA; v.expB = eB; v.expCnt = eC;
        return v;
    endfunction

    // Search the recent history for the newest writer of rs.
    // Distance 1 feeds from EX/MEM and distance 2 from MEM/WB.
    // Anything older has already been written to the register file.
    function automatic logic [1:0] modelSel(input logic [4:0] rs, input logic useIt);
        if (!useIt) return 2'b00;
        for (int d = 0; d < 2; d++) begin
            if (hist[d].w && hist[d].rd == rs) return (d == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    // The instruction stalls when the newest issued instruction is a load whose result it reads.
    function automatic logic modelStall();
        logic hit;
        hit = hist[0].w && hist[0].ld &&
              ((id_use_rs1 && hist[0].rd == id_rs1) || (id_use_rs2 && hist[0].rd == id_rs2));
        return RST_N && id_valid && !flush && hit;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit useTable);
        logic ms;
        logic gate;
        issued_t nw;
        @(negedge CLK);
        RST_N = v.rst_n; id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_rd = v.rd;
        id_reg_write = v.rw; id_is_load = v.ld; flush = v.fl;
        #1;
        ms = modelStall();
        checkOutput("stall", 32'(stall), 32'(ms));
        checkOutput("stall_sat", 32'(stall_s), 32'(ms));
        if (useTable) checkOutput("stall_tbl", 32'(stall), 32'(v.expStall));
        if (!v.rst_n) begin
            hist[0] = '{1'b0, 5'd0, 1'b0};
            hist[1] = '{1'b0, 5'd0, 1'b0};
            mA = 2'b00; mB = 2'b00; c16 = 0; c2 = 0;
        end else begin
            gate = !v.valid || ms || v.fl;
            mA = gate ? 2'b00 : modelSel(v.rs1, v.u1);
            mB = gate ? 2'b00 : modelSel(v.rs2, v.u2);
            if (ms) begin
                if (c16 < (1 << CW) - 1) c16++;
                if (c2 < (1 << SW) - 1) c2++;
            end
            nw.w  = v.valid && v.rw && (v.rd != 5'd0) && !ms && !v.fl;
            nw.rd = v.rd;
            nw.ld = v.ld;
            hist[1] = hist[0];
            hist[0] = nw;
        end
        @(posedge CLK);
        #1;
        checkOutput("fwd_a", 32'(fwd_a), 32'(mA));
        checkOutput("fwd_b", 32'(fwd_b), 32'(mB));
        checkOutput("stall_count", 32'(stall_count), 32'(c16));
        checkOutput("fwd_a_sat", 32'(fwd_a_s), 32'(mA));
        checkOutput("fwd_b_sat", 32'(fwd_b_s), 32'(mB));
        checkOutput("count_sat", 32'(cnt_s), 32'(c2));
        if (useTable) begin
            checkOutput("fwd_a_tbl", 32'(fwd_a), 32'(v.expA));
            checkOutput("fwd_b_tbl", 32'(fwd_b), 32'(v.expB));
            checkOutput("count_tbl", 32'(stall_count), 32'(v.expCnt));
            checkOutput("count_sat_tbl", 32'(cnt_s), 32'((v.expCnt > 3) ? 3 : v.expCnt));
        end
    endtask

    initial begin
        vec_t v;
        hist[0] = '{1'b0, 5'd0, 1'b0};
        hist[1] = '{1'b0, 5'd0, 1'b0};
        mA = 2'b00; mB = 2'b00; c16 = 0; c2 = 0;
        RST_N = 1'b0; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = 5'd0;
        id_reg_write = 1'b0; id_is_load = 1'b0; flush = 1'b0;

        // reset held with a load-use shape on the inputs, then reset with a load in EX
        tbl.push_back(mk(0,1, 7, 0,1,0, 7,1,1,0, 0,2'b00,2'b00,0));
        tbl.push_back(mk(0,1, 7, 7,1,1, 7,1,1,0, 0,2'b00,2'b00,0));
        tbl.push_back(mk(1,1, 0, 0,0,0, 7,1,1,0, 0,2'b00,2'b00,0));
        tbl.push_back(mk(0,1, 7, 7,1,1,14,1,0,0, 0,2'b00,2'b00,0));
        tbl.push_back(mk(1,1, 7, 7,1,1,14,0,0,0, 0,2'b00,2'b00,0));
        // ALU at distance 1, 2 and 3
        tbl.push_back(mk(1,1, 1, 2,1,1, 5,1,0,0, 0,2'b00,2'b00,0));
        tbl.push_back(mk(1,1, 5, 6,1,1, 8,1,0,0, 0,2'b10,2'b00,0));
        tbl.push_back(mk(1,1, 0, 0,0,0,11,1,0,0, 0,2'b00,2'b00,0));
        tbl.push_back(mk(1,0, 0, 0,0,0, 0,0,0,0, 0,2'b00,2'b00,0));
        tbl.push_back(mk(1,1, 1,11,1,1,12,1,0,0, 0,2'b00,2'b01,0));
        tbl.push_back(mk(1,1, 0,11,0,1,13,1,0,0, 0,2'b00,2'b00,0));
        // load-use on both sources
        tbl.push_back(mk(1,1, 2, 0,1,0, 7,1,1,0, 0,2'b00,2'b00,0));
        tbl.push_back(mk(1,1, 7, 7,1,1,14,1,0,0, 1,2'b00,2'b00,1));
        tbl.push_back(mk(1,1, 7, 7,1,1,14,1,0,0, 0,2'b01,2'b01,1));
        // x0 never forwards; EX beats MEM for the same rd
        tbl.push_back(mk(1,1, 0, 0,0,0, 0,1,0,0, 0,2'b00,2'b00,1));
        tbl.push_back(mk(1,1, 0, 0,1,1,15,1,0,0, 0,2'b00,2'b00,1));
        tbl.push_back(mk(1,1, 0, 0,0,0, 3,1,0,0, 0,2'b00,2'b00,1));
        tbl.push_back(mk(1,1, 0, 0,0,0, 3,1,0,0, 0,2'b00,2'b00,1));
        tbl.push_back(mk(1,1, 3, 3,1,1,16,1,0,0, 0,2'b10,2'b10,1));
        // flush wins over load-use and leaves a bubble in EX
        tbl.push_back(mk(1,1, 0, 0,0,0, 9,1,1,0, 0,2'b00,2'b00,1));
        tbl.push_back(mk(1,1, 9, 0,1,0,20,1,0,1, 0,2'b00,2'b00,1));
        tbl.push_back(mk(1,1,20, 9,1,1,21,1,0,0, 0,2'b00,2'b01,1));
        // five more load-use stalls to drive the narrow counter into saturation
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mk(1,1,0,0,0,0, 7,1,1,0, 0,2'b00,2'b00,1+k));
            tbl.push_back(mk(1,1,7,0,1,0,22,0,0,0, 1,2'b00,2'b00,2+k));
            tbl.push_back(mk(1,1,7,0,1,0,22,0,0,0, 0,2'b01,2'b00,2+k));
        end

        foreach (tbl[i]) applyStimulus(tbl[i], 1'b1);

        // random traffic over a small register range so that hazards are frequent
        for (int n = 0; n < 500; n++) begin
            v.rst_n = ($urandom_range(0, 99) >= 3);
            v.valid = ($urandom_range(0, 7) != 0);
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.u1    = 1'($urandom_range(0, 1));
            v.u2    = 1'($urandom_range(0, 1));
            v.rd    = 5'($urandom_range(0, 3));
            v.rw    = ($urandom_range(0, 3) != 0);
            v.ld    = ($urandom_range(0, 2) == 0);
            v.fl    = ($urandom_range(0, 9) == 0);
            v.expStall = 1'b0; v.expA = 2'b00; v.expB = 2'b00; v.expCnt = 0;
            applyStimulus(v, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
